// File: rtl/pcie_ss_tag_tracker.sv
`default_nettype none
// ============================================================================
// Module      : pcie_ss_tag_tracker
// Description : Passive monitor for the PCIe SS AXI-S host channels. Snoops
//               TX memory-read requests and RX completions. Keeps a per-tag
//               scoreboard of outstanding non-posted reads. Reports retire
//               latency and sticky protocol errors: duplicate tag, unexpected
//               completion and completion timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module pcie_ss_tag_tracker #(
    parameter int unsigned TDATA_WIDTH = 512,        // >= 256
    parameter int unsigned TAG_W       = 10,         // <= 10 (PCIe 10-bit tags)
    parameter int unsigned TS_W        = 16,
    parameter int unsigned TIMEOUT     = 16'd40000   // < 2**TS_W
) (
    input  logic                   clk,
    input  logic                   rst_n,

    input  logic                   tx_tvalid,
    input  logic                   tx_tready,
    input  logic                   tx_tlast,
    input  logic [TDATA_WIDTH-1:0] tx_tdata,

    input  logic                   rx_tvalid,
    input  logic                   rx_tready,
    input  logic                   rx_tlast,
    input  logic [TDATA_WIDTH-1:0] rx_tdata,

    input  logic                   err_clr,

    output logic [TAG_W:0]         outstanding,
    output logic                   lat_valid,
    output logic [TAG_W-1:0]       lat_tag,
    output logic [TS_W-1:0]        lat_cycles,
    output logic                   err_dup_tag,
    output logic                   err_unexp_cpl,
    output logic                   err_timeout,
    output logic [TAG_W-1:0]       err_tag
);

    localparam int unsigned      C_NUM_TAGS  = 1 << TAG_W;
    localparam logic [TS_W-1:0]  C_TIMEOUT   = TS_W'(TIMEOUT);
    localparam logic [7:0]       C_FMT_MRD32 = 8'h00;
    localparam logic [7:0]       C_FMT_MRD64 = 8'h20;
    localparam logic [7:0]       C_FMT_CPL   = 8'h0A;
    localparam logic [7:0]       C_FMT_CPLD  = 8'h4A;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic                  r_tx_sop;
    logic                  r_rx_sop;
    logic [TS_W-1:0]       r_ts_now;
    logic [TAG_W-1:0]      r_scan_ptr;
    logic [C_NUM_TAGS-1:0] r_valid;
    logic [TS_W-1:0]       r_ts [C_NUM_TAGS];

    logic [TAG_W:0]        r_outstanding;
    logic                  r_lat_valid;
    logic [TAG_W-1:0]      r_lat_tag;
    logic [TS_W-1:0]       r_lat_cycles;
    logic                  r_err_dup;
    logic                  r_err_unexp;
    logic                  r_err_to;
    logic [TAG_W-1:0]      r_err_tag;

    // ------------------------------------------------------------------------
    // Header decode (only meaningful on accepted start-of-packet beats)
    // ------------------------------------------------------------------------
    logic             w_tx_acc;
    logic             w_rx_acc;
    logic [7:0]       w_tx_fmt;
    logic [7:0]       w_rx_fmt;
    logic [9:0]       w_tx_tag_raw;
    logic [9:0]       w_rx_tag_raw;
    logic [TAG_W-1:0] w_tx_tag;
    logic [TAG_W-1:0] w_rx_tag;
    logic             w_rx_fc;

    assign w_tx_acc     = tx_tvalid & tx_tready;
    assign w_rx_acc     = rx_tvalid & rx_tready;
    assign w_tx_fmt     = tx_tdata[31:24];
    assign w_rx_fmt     = rx_tdata[31:24];
    // Request tag is split: tag[9] in bit 23, tag[8] in bit 19, tag[7:0] in 47:40.
    assign w_tx_tag_raw = {tx_tdata[23], tx_tdata[19], tx_tdata[47:40]};
    assign w_rx_tag_raw = rx_tdata[127:118];
    assign w_tx_tag     = w_tx_tag_raw[TAG_W-1:0];
    assign w_rx_tag     = w_rx_tag_raw[TAG_W-1:0];
    assign w_rx_fc      = rx_tdata[78];

    // Only header fields are looked at; the rest of each beat is ignored.
    logic w_unused;
    assign w_unused = ^{tx_tdata, rx_tdata, w_tx_tag_raw, w_rx_tag_raw};

    // ------------------------------------------------------------------------
    // Event resolution
    // ------------------------------------------------------------------------
    logic            w_alloc;
    logic            w_cpl;
    logic            w_cpl_hit;
    logic            w_retire;
    logic            w_unexp;
    logic            w_same_ret_alloc;
    logic            w_dup;
    logic            w_alloc_new;
    logic [TS_W-1:0] w_scan_age;
    logic [TS_W-1:0] w_cpl_age;
    logic            w_timeout;

    assign w_alloc   = w_tx_acc & r_tx_sop &
                       ((w_tx_fmt == C_FMT_MRD32) | (w_tx_fmt == C_FMT_MRD64));
    assign w_cpl     = w_rx_acc & r_rx_sop &
                       ((w_rx_fmt == C_FMT_CPL) | (w_rx_fmt == C_FMT_CPLD));
    assign w_cpl_hit = r_valid[w_rx_tag];

    // Any completion against an empty entry is unexpected; only FC=1 retires.
    assign w_retire  = w_cpl & w_rx_fc & w_cpl_hit;
    assign w_unexp   = w_cpl & ~w_cpl_hit;

    // A retire of the same tag in the same cycle frees the entry first, so the
    // new request reuses it cleanly and is not a duplicate.
    assign w_same_ret_alloc = w_retire & (w_rx_tag == w_tx_tag);
    assign w_dup            = w_alloc & r_valid[w_tx_tag] & ~w_same_ret_alloc;
    // Alloc adds to the count unless it merely overwrote a live entry.
    assign w_alloc_new      = w_alloc & ~w_dup;

    // Ages are modular differences so a wrapping timestamp counter is harmless.
    assign w_scan_age = r_ts_now - r_ts[r_scan_ptr];
    assign w_cpl_age  = r_ts_now - r_ts[w_rx_tag];

    // A retire or alloc touching the scanned entry this cycle takes precedence.
    assign w_timeout = r_valid[r_scan_ptr] & (w_scan_age >= C_TIMEOUT) &
                       ~(w_retire & (w_rx_tag == r_scan_ptr)) &
                       ~(w_alloc  & (w_tx_tag == r_scan_ptr));

    logic [TAG_W:0] w_outstanding_nxt;
    assign w_outstanding_nxt = r_outstanding
                             + (TAG_W+1)'(w_alloc_new)
                             - (TAG_W+1)'(w_retire)
                             - (TAG_W+1)'(w_timeout);

    // Error capture: first error since clear wins; unexp > dup > timeout.
    logic             w_err_new;
    logic             w_err_any;
    logic [TAG_W-1:0] w_err_tag_sel;

    assign w_err_new     = w_unexp | w_dup | w_timeout;
    assign w_err_any     = r_err_dup | r_err_unexp | r_err_to;
    assign w_err_tag_sel = w_unexp ? w_rx_tag :
                           w_dup   ? w_tx_tag : r_scan_ptr;

    // ------------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------------

    // Per-channel packet framing: the beat after a tlast beat is a header.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_sop <= 1'b1;
            r_rx_sop <= 1'b1;
        end else begin
            if (w_tx_acc) r_tx_sop <= tx_tlast;
            if (w_rx_acc) r_rx_sop <= rx_tlast;
        end
    end

    // Free-running timestamp and round-robin timeout scan pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ts_now   <= '0;
            r_scan_ptr <= '0;
        end else begin
            r_ts_now   <= r_ts_now + 1'b1;
            r_scan_ptr <= r_scan_ptr + 1'b1;
        end
    end

    // Valid bits: clears applied before the alloc so a same-cycle alloc wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else begin
            if (w_timeout) r_valid[r_scan_ptr] <= 1'b0;
            if (w_retire)  r_valid[w_rx_tag]   <= 1'b0;
            if (w_alloc)   r_valid[w_tx_tag]   <= 1'b1;
        end
    end

    // Issue timestamps; contents only matter where the valid bit is set.
    always_ff @(posedge clk) begin
        if (w_alloc) r_ts[w_tx_tag] <= r_ts_now;
    end

    // Outstanding request count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outstanding <= '0;
        end else begin
            r_outstanding <= w_outstanding_nxt;
        end
    end

    // Latency report: one-cycle pulse per retire, tag/cycles held between.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lat_valid  <= 1'b0;
            r_lat_tag    <= '0;
            r_lat_cycles <= '0;
        end else begin
            r_lat_valid <= w_retire;
            if (w_retire) begin
                r_lat_tag    <= w_rx_tag;
                r_lat_cycles <= w_cpl_age;
            end
        end
    end

    // Sticky error flags and first-error tag; a clear drops same-cycle errors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_dup   <= 1'b0;
            r_err_unexp <= 1'b0;
            r_err_to    <= 1'b0;
            r_err_tag   <= '0;
        end else if (err_clr) begin
            r_err_dup   <= 1'b0;
            r_err_unexp <= 1'b0;
            r_err_to    <= 1'b0;
            r_err_tag   <= '0;
        end else begin
            if (w_dup)     r_err_dup   <= 1'b1;
            if (w_unexp)   r_err_unexp <= 1'b1;
            if (w_timeout) r_err_to    <= 1'b1;
            if (w_err_new && !w_err_any) r_err_tag <= w_err_tag_sel;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign outstanding   = r_outstanding;
    assign lat_valid     = r_lat_valid;
    assign lat_tag       = r_lat_tag;
    assign lat_cycles    = r_lat_cycles;
    assign err_dup_tag   = r_err_dup;
    assign err_unexp_cpl = r_err_unexp;
    assign err_timeout   = r_err_to;
    assign err_tag       = r_err_tag;

endmodule
`default_nettype wire

// File: tb/tb_pcie_ss_tag_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_pcie_ss_tag_tracker
// Description : Scoreboard bench for pcie_ss_tag_tracker. A tag-level
//               reference model predicts every cycle's status and each
//               retire's latency; a monitor compares the DUT against them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pcie_ss_tag_tracker;

    localparam int TDW   = 512;
    localparam int TAG_W = 10;
    localparam int TS_W  = 16;
    localparam int TO    = 200;
    localparam int NT    = 1 << TAG_W;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             tx_tvalid = 1'b0, tx_tready = 1'b0, tx_tlast = 1'b0;
    logic [TDW-1:0]   tx_tdata = '0;
    logic             rx_tvalid = 1'b0, rx_tready = 1'b0, rx_tlast = 1'b0;
    logic [TDW-1:0]   rx_tdata = '0;
    logic             err_clr = 1'b0;
    logic [TAG_W:0]   outstanding;
    logic             lat_valid;
    logic [TAG_W-1:0] lat_tag;
    logic [TS_W-1:0]  lat_cycles;
    logic             err_dup_tag, err_unexp_cpl, err_timeout;
    logic [TAG_W-1:0] err_tag;

    always #5 clk = ~clk;

    pcie_ss_tag_tracker #(
        .TDATA_WIDTH (TDW),
        .TAG_W       (TAG_W),
        .TS_W        (TS_W),
        .TIMEOUT     (TO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .tx_tvalid     (tx_tvalid),
        .tx_tready     (tx_tready),
        .tx_tlast      (tx_tlast),
        .tx_tdata      (tx_tdata),
        .rx_tvalid     (rx_tvalid),
        .rx_tready     (rx_tready),
        .rx_tlast      (rx_tlast),
        .rx_tdata      (rx_tdata),
        .err_clr       (err_clr),
        .outstanding   (outstanding),
        .lat_valid     (lat_valid),
        .lat_tag       (lat_tag),
        .lat_cycles    (lat_cycles),
        .err_dup_tag   (err_dup_tag),
        .err_unexp_cpl (err_unexp_cpl),
        .err_timeout   (err_timeout),
        .err_tag       (err_tag)
    );

    typedef struct packed {
        logic [TAG_W:0]   outst;
        logic             dup;
        logic             unexp;
        logic             tmo;
        logic [TAG_W-1:0] etag;
        logic             latv;
    } exp_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [TS_W-1:0]  cyc;
    } lat_t;

    exp_t exp_q[$];
    lat_t lat_q[$];
    int   n_cmp = 0;
    int   n_mis = 0;

    // ---------------- reference model (tag-level) ----------------
    bit          m_valid [NT];
    int unsigned m_stamp [NT];
    int unsigned m_now, m_scan;
    bit          m_tx_sop, m_rx_sop;
    bit          m_dup, m_unexp, m_tmo;
    int unsigned m_etag;

    task automatic model_reset();
        for (int i = 0; i < NT; i++) begin
            m_valid[i] = 1'b0;
            m_stamp[i] = 0;
        end
        m_now = 0; m_scan = 0;
        m_tx_sop = 1'b1; m_rx_sop = 1'b1;
        m_dup = 1'b0; m_unexp = 1'b0; m_tmo = 1'b0; m_etag = 0;
    endtask

    task automatic model_push(input bit latv);
        exp_t e;
        int   cnt;
        cnt = 0;
        for (int i = 0; i < NT; i++) if (m_valid[i]) cnt++;
        e.outst = cnt[TAG_W:0];
        e.dup   = m_dup;
        e.unexp = m_unexp;
        e.tmo   = m_tmo;
        e.etag  = m_etag[TAG_W-1:0];
        e.latv  = latv;
        exp_q.push_back(e);
    endtask

    task automatic model_step(input logic txv, txr, txl, input logic [TDW-1:0] txd,
                              input logic rxv, rxr, rxl, input logic [TDW-1:0] rxd,
                              input logic clr);
        bit          is_req, is_cpl, fc, retire, unexp, dup, tmo;
        int unsigned at, rt, age;
        lat_t        l;
        at     = {txd[23], txd[19], txd[47:40]};
        rt     = rxd[127:118];
        fc     = rxd[78];
        is_req = txv && txr && m_tx_sop && (txd[31:24] == 8'h00 || txd[31:24] == 8'h20);
        is_cpl = rxv && rxr && m_rx_sop && (rxd[31:24] == 8'h0A || rxd[31:24] == 8'h4A);
        retire = 1'b0; unexp = 1'b0; dup = 1'b0; tmo = 1'b0;
        if (is_cpl) begin
            if (!m_valid[rt]) unexp = 1'b1;
            else if (fc) begin
                retire = 1'b1;
                l.tag  = rt[TAG_W-1:0];
                l.cyc  = TS_W'((m_now - m_stamp[rt]) % 65536);
                lat_q.push_back(l);
            end
        end
        if (is_req && m_valid[at] && !(retire && rt == at)) dup = 1'b1;
        age = (m_now - m_stamp[m_scan]) % 65536;
        if (m_valid[m_scan] && age >= TO && !(retire && rt == m_scan) && !(is_req && at == m_scan))
            tmo = 1'b1;
        if (tmo)    m_valid[m_scan] = 1'b0;
        if (retire) m_valid[rt] = 1'b0;
        if (is_req) begin
            m_valid[at] = 1'b1;
            m_stamp[at] = m_now;
        end
        if (clr) begin
            m_dup = 1'b0; m_unexp = 1'b0; m_tmo = 1'b0; m_etag = 0;
        end else begin
            if (!(m_dup || m_unexp || m_tmo) && (unexp || dup || tmo))
                m_etag = unexp ? rt : (dup ? at : m_scan);
            m_dup   = m_dup | dup;
            m_unexp = m_unexp | unexp;
            m_tmo   = m_tmo | tmo;
        end
        if (txv && txr) m_tx_sop = txl;
        if (rxv && rxr) m_rx_sop = rxl;
        m_now  = (m_now + 1) % 65536;
        m_scan = (m_scan + 1) % NT;
        model_push(retire);
    endtask

    // ---------------- stimulus helpers ----------------
    function automatic logic [TDW-1:0] rand_data();
        logic [TDW-1:0] d;
        for (int i = 0; i < TDW / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    function automatic logic [TDW-1:0] mk_tx(input logic [7:0] fmt, input logic [9:0] tag);
        logic [TDW-1:0] d;
        d = rand_data();
        d[31:24] = fmt;
        d[23]    = tag[9];
        d[19]    = tag[8];
        d[47:40] = tag[7:0];
        return d;
    endfunction

    function automatic logic [TDW-1:0] mk_rx(input logic [7:0] fmt, input logic [9:0] tag, input logic fc);
        logic [TDW-1:0] d;
        d = rand_data();
        d[31:24]   = fmt;
        d[127:118] = tag;
        d[78]      = fc;
        return d;
    endfunction

    function automatic logic [9:0] rand_tag();
        logic [9:0] t;
        t = 10'($urandom_range(0, 15));
        if ($urandom_range(0, 3) == 0) t[9:8] = 2'b11;
        return t;
    endfunction

    task automatic drive(input logic txv, txr, txl, input logic [TDW-1:0] txd,
                         input logic rxv, rxr, rxl, input logic [TDW-1:0] rxd,
                         input logic clr);
        @(negedge clk);
        rst_n     = 1'b1;
        tx_tvalid = txv; tx_tready = txr; tx_tlast = txl; tx_tdata = txd;
        rx_tvalid = rxv; rx_tready = rxr; rx_tlast = rxl; rx_tdata = rxd;
        err_clr   = clr;
        model_step(txv, txr, txl, txd, rxv, rxr, rxl, rxd, clr);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic tx_only(input logic last, input logic [TDW-1:0] d);
        drive(1'b1, 1'b1, last, d, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic rx_only(input logic [TDW-1:0] d);
        drive(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1, d, 1'b0);
    endtask

    task automatic clear_errs();
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    endtask

    task automatic reset_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            rst_n     = 1'b0;
            tx_tvalid = 1'b0; tx_tready = 1'b0; tx_tlast = 1'b0;
            rx_tvalid = 1'b0; rx_tready = 1'b0; rx_tlast = 1'b0;
            err_clr   = 1'b0;
            model_reset();
            model_push(1'b0);
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    exp_t mon_e;
    lat_t mon_l;
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("outstanding",   32'(outstanding),   32'(mon_e.outst));
            check("err_dup_tag",   32'(err_dup_tag),   32'(mon_e.dup));
            check("err_unexp_cpl", 32'(err_unexp_cpl), 32'(mon_e.unexp));
            check("err_timeout",   32'(err_timeout),   32'(mon_e.tmo));
            check("err_tag",       32'(err_tag),       32'(mon_e.etag));
            check("lat_valid",     32'(lat_valid),     32'(mon_e.latv));
        end
        if (lat_valid === 1'b1) begin
            if (lat_q.size() == 0) begin
                n_cmp++;
                n_mis++;
                $display("FAIL lat_unexpected: got lat_valid=1 tag=0x%0h expected no retire", lat_tag);
            end else begin
                mon_l = lat_q.pop_front();
                check("lat_tag",    32'(lat_tag),    32'(mon_l.tag));
                check("lat_cycles", 32'(lat_cycles), 32'(mon_l.cyc));
            end
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        model_reset();
        reset_cycles(3);

        // Latency: alloc tag 0x005 at ts=100, completion at ts=160 -> 60.
        while (m_now != 100) idle(1);
        tx_only(1'b1, mk_tx(8'h00, 10'h005));
        while (m_now != 160) idle(1);
        rx_only(mk_rx(8'h4A, 10'h005, 1'b1));
        idle(3);

        // Duplicate tag 0x010, then clear, then retire it.
        tx_only(1'b1, mk_tx(8'h20, 10'h010));
        idle(2);
        tx_only(1'b1, mk_tx(8'h00, 10'h010));
        idle(2);
        clear_errs();
        rx_only(mk_rx(8'h0A, 10'h010, 1'b1));
        idle(2);

        // Unexpected completion 0x3FF; FC=0 on a valid tag is silent.
        rx_only(mk_rx(8'h4A, 10'h3FF, 1'b1));
        idle(2);
        clear_errs();
        tx_only(1'b1, mk_tx(8'h00, 10'h020));
        rx_only(mk_rx(8'h4A, 10'h020, 1'b0));
        idle(2);
        rx_only(mk_rx(8'h4A, 10'h020, 1'b1));
        idle(2);

        // Timeout on tag 3.
        tx_only(1'b1, mk_tx(8'h00, 10'h003));
        idle(TO + NT + 4);
        clear_errs();

        // Same-cycle retire and re-alloc of tag 7.
        tx_only(1'b1, mk_tx(8'h00, 10'h007));
        idle(5);
        drive(1'b1, 1'b1, 1'b1, mk_tx(8'h20, 10'h007),
              1'b1, 1'b1, 1'b1, mk_rx(8'h4A, 10'h007, 1'b1), 1'b0);
        idle(3);
        rx_only(mk_rx(8'h4A, 10'h007, 1'b1));
        idle(2);

        // 4-beat write: beat 2 carries MRd32 fmt but is not a header.
        tx_only(1'b0, mk_tx(8'h40, 10'h001));
        tx_only(1'b0, mk_tx(8'h00, 10'h002));
        tx_only(1'b0, mk_tx(8'h00, 10'h003));
        tx_only(1'b1, mk_tx(8'h00, 10'h004));
        idle(2);

        // Reset mid-packet; next beat is a header again.
        tx_only(1'b1, mk_tx(8'h00, 10'h00A));
        tx_only(1'b0, mk_tx(8'h40, 10'h001));
        reset_cycles(2);
        tx_only(1'b1, mk_tx(8'h00, 10'h00B));
        idle(2);
        rx_only(mk_rx(8'h0A, 10'h00B, 1'b1));
        idle(2);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] tf, rf;
            case ($urandom_range(0, 4))
                0: tf = 8'h00;
                1: tf = 8'h20;
                2: tf = 8'h40;
                3: tf = 8'h00;
                default: tf = 8'($urandom);
            endcase
            case ($urandom_range(0, 4))
                0: rf = 8'h0A;
                1: rf = 8'h4A;
                2: rf = 8'h4A;
                3: rf = 8'h4A;
                default: rf = 8'($urandom);
            endcase
            drive(($urandom % 4) != 0, ($urandom % 4) != 0, ($urandom % 3) != 0,
                  mk_tx(tf, rand_tag()),
                  ($urandom % 4) != 0, ($urandom % 4) != 0, ($urandom % 3) != 0,
                  mk_rx(rf, rand_tag(), ($urandom % 4) != 0),
                  ($urandom % 64) == 0);
        end

        // Drain: everything left must time out.
        idle(TO + NT + 20);
        @(negedge clk);
        check("exp_queue_empty", 32'(exp_q.size()), 32'd0);
        check("lat_queue_empty", 32'(lat_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
